pulse_qual: RTL and testbench

Input conditioning stage that sits directly upstream of the pulse stretcher. It synchronizes an asynchronous pulse input and rejects glitches shorter than MIN_TICKS. Qualified pulses are re-emitted with their original width, clamped to MAX_LENGTH_TICKS. A holdoff window after each emitted pulse keeps the stretcher out of its pending phase when a new pulse arrives, and the block reports the measured length and counts of rejected and dropped pulses.

---
 rtl/pulse_qual.sv | 121 ++++++++++++
 tb/tb_pulse_qual.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_qual.sv
// pulse_qual: synchronize, deglitch and width-clamp an async pulse, with post-pulse holdoff
module pulse_qual #(
    parameter int SYNC_STAGES      = 2,
    parameter int MIN_TICKS        = 4,
    parameter int MAX_LENGTH_TICKS = 100,
    parameter int HOLDOFF_TICKS    = 400,
    parameter int CNT_W            = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in,
    output logic                                  out,
    output logic [$clog2(MAX_LENGTH_TICKS+1)-1:0] len,
    output logic                                  len_vld,
    output logic                                  busy,
    output logic [CNT_W-1:0]                      rej_cnt,
    output logic [CNT_W-1:0]                      drop_cnt
);
    localparam int LW = $clog2(MAX_LENGTH_TICKS + 1);
    localparam int TW = $clog2(HOLDOFF_TICKS + 2);
    localparam int QW = $clog2(MIN_TICKS + SYNC_STAGES + 1);

    typedef enum logic [2:0] {ARM, IDLE, QUAL, PASS, HOLD} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic [MIN_TICKS-1:0]   dl;
    logic                   s_in, s_prev, dl_out;
    logic [QW-1:0]          cnt, cnt_nx;
    logic [LW-1:0]          len_ctr, len_ctr_nx, len_nx;
    logic [TW-1:0]          timer, timer_nx;
    logic                   out_nx, vld_nx, rej_inc, drop_inc;

    assign s_in   = sync[SYNC_STAGES-1];
    assign dl_out = dl[MIN_TICKS-1];

    // Registers: synchronizer, delay line, FSM state and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= '0;
            dl       <= '0;
            s_prev   <= 1'b0;
            state    <= ARM;
            cnt      <= '0;
            len_ctr  <= '0;
            timer    <= '0;
            out      <= 1'b0;
            len      <= '0;
            len_vld  <= 1'b0;
            busy     <= 1'b0;
            rej_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            sync     <= (sync << 1) | SYNC_STAGES'(in);
            dl       <= (dl << 1) | MIN_TICKS'(s_in);
            s_prev   <= s_in;
            state    <= state_nx;
            cnt      <= cnt_nx;
            len_ctr  <= len_ctr_nx;
            timer    <= timer_nx;
            out      <= out_nx;
            len      <= len_nx;
            len_vld  <= vld_nx;
            busy     <= state_nx != IDLE;
            if (rej_inc && rej_cnt != '1) rej_cnt <= rej_cnt + 1'b1;
            if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Next state: ARM lets the synchronizer fill before trusting s_in; PASS replays the delayed copy
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        len_ctr_nx = len_ctr;
        timer_nx   = timer;
        out_nx     = 1'b0;
        len_nx     = len;
        vld_nx     = 1'b0;
        rej_inc    = 1'b0;
        drop_inc   = 1'b0;
        case (state)
            ARM: begin
                if (cnt != QW'(SYNC_STAGES)) cnt_nx = cnt + 1'b1;
                else if (!s_in) state_nx = IDLE;
            end
            IDLE: begin
                if (s_in) begin
                    cnt_nx     = QW'(1);
                    len_ctr_nx = '0;
                    state_nx   = (MIN_TICKS == 1) ? PASS : QUAL;
                end
            end
            QUAL: begin
                if (!s_in) begin
                    rej_inc  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx   = cnt + 1'b1;
                    state_nx = (cnt == QW'(MIN_TICKS - 1)) ? PASS : QUAL;
                end
            end
            PASS: begin
                if (out && (!dl_out || len_ctr == LW'(MAX_LENGTH_TICKS))) begin
                    len_nx   = len_ctr;
                    vld_nx   = 1'b1;
                    timer_nx = TW'(HOLDOFF_TICKS);
                    state_nx = HOLD;
                end else begin
                    out_nx     = dl_out;
                    len_ctr_nx = len_ctr + LW'(dl_out);
                end
            end
            HOLD: begin
                timer_nx = (timer != '0) ? timer - 1'b1 : timer;
                drop_inc = s_in & ~s_prev;
                state_nx = (timer == '0 && !s_in) ? IDLE : HOLD;
            end
            default: state_nx = ARM;
        endcase
    end
endmodule

// File: tb/tb_pulse_qual.sv
// tb_pulse_qual: directed and randomized pulse trains checked against a pulse-level model
module tb_pulse_qual;
    localparam int SYNC = 2, MIN = 4, MAXL = 100, HOLD = 400, LW = $clog2(MAXL + 1);
    localparam int NMAX = 4096;

    logic clk = 1'b0, rst = 1'b1, in = 1'b0;
    logic out, len_vld, busy, out2, vld2, busy2;
    logic [LW-1:0] len, len2;
    logic [15:0] rej_cnt, drop_cnt;
    logic [1:0] rej2, drop2;
    int passed = 0, total = 0;

    bit r[NMAX];
    bit ex_out[NMAX+64], ex_vld[NMAX+64], ex_busy[NMAX+64];
    int ex_len[NMAX+64];
    bit ob_out[NMAX], ob_vld[NMAX], ob_busy[NMAX];
    int ob_len[NMAX];
    int ex_rej, ex_drop;

    always #5 clk = ~clk;

    pulse_qual #(.SYNC_STAGES(SYNC), .MIN_TICKS(MIN), .MAX_LENGTH_TICKS(MAXL), .HOLDOFF_TICKS(HOLD), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in(in), .out(out), .len(len), .len_vld(len_vld),
        .busy(busy), .rej_cnt(rej_cnt), .drop_cnt(drop_cnt));

    pulse_qual #(.SYNC_STAGES(SYNC), .MIN_TICKS(MIN), .MAX_LENGTH_TICKS(MAXL), .HOLDOFF_TICKS(HOLD), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in(in), .out(out2), .len(len2), .len_vld(vld2),
        .busy(busy2), .rej_cnt(rej2), .drop_cnt(drop2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reset with in low, then idle long enough to leave ARM
    task automatic prep();
        for (int k = 0; k < NMAX; k++) r[k] = 0;
        in = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (8) tick();
    endtask

    // synchronized input as seen by the FSM at edge e of the run
    function automatic bit s_at(input int e, input int n);
        return (e >= SYNC && e - SYNC < n) ? r[e-SYNC] : 1'b0;
    endfunction

    // pulse-level model: each run of s_in is rejected, emitted or dropped by timing rules
    task automatic model(input int n, input bit arm);
        int ready, w, ew, t, x;
        bit emitted;
        for (int k = 0; k < NMAX + 64; k++) begin
            ex_out[k] = 0; ex_vld[k] = 0; ex_busy[k] = 0; ex_len[k] = 0;
        end
        ex_rej = 0;
        ex_drop = 0;
        emitted = 0;
        ready = 0;
        if (arm) begin
            x = SYNC;
            while (s_at(x, n)) x++;
            ready = x + 1;
            for (int k = 0; k < x; k++) ex_busy[k] = 1;
        end
        for (int e = 0; e < n; e++) begin
            if (s_at(e, n) && !s_at(e - 1, n)) begin
                w = 0;
                while (s_at(e + w, n)) w++;
                if (e >= ready) begin
                    if (w < MIN) begin
                        ex_rej++;
                        for (int k = e; k < e + w; k++) ex_busy[k] = 1;
                    end else begin
                        ew = (w < MAXL) ? w : MAXL;
                        for (int k = 0; k < ew; k++) ex_out[e+MIN+k] = 1;
                        t = e + MIN + ew;
                        ex_vld[t] = 1;
                        ex_len[t] = ew;
                        x = t + HOLD + 1;
                        while (s_at(x, n)) x++;
                        ready = x + 1;
                        for (int k = e; k < x; k++) ex_busy[k] = 1;
                        emitted = 1;
                    end
                end else if (emitted) ex_drop++;
            end
        end
        for (int e = 1; e < NMAX + 64; e++) if (!ex_vld[e]) ex_len[e] = ex_len[e-1];
    endtask

    // drive r[] one sample per edge and record outputs just after each edge
    task automatic run(input int n);
        for (int e = 0; e < n; e++) begin
            in = r[e];
            tick();
            ob_out[e] = out;
            ob_vld[e] = len_vld;
            ob_busy[e] = busy;
            ob_len[e] = int'(len);
        end
    endtask

    function automatic int trace_errs(input int n, output int first);
        int m = 0;
        first = -1;
        for (int e = 0; e < n; e++)
            if (ob_out[e] !== ex_out[e] || ob_busy[e] !== ex_busy[e] || ob_vld[e] !== ex_vld[e] || ob_len[e] != ex_len[e]) begin
                if (first < 0) first = e;
                m++;
            end
        return m;
    endfunction

    task automatic test_reset();
        in = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (out !== 1'b0) $display("FAIL reset_out: got %b want 0", out); else passed++;
        total++; if (len !== '0) $display("FAIL reset_len: got %0d want 0", len); else passed++;
        total++; if (len_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", len_vld); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (rej_cnt !== '0 || drop_cnt !== '0) $display("FAIL reset_cnts: got %0d/%0d want 0/0", rej_cnt, drop_cnt); else passed++;
        tick();
        total++; if (busy !== 1'b1) $display("FAIL arm_busy: got %b want 1", busy); else passed++;
        repeat (5) tick();
        total++; if (busy !== 1'b0) $display("FAIL arm_exit: got busy %b want 0", busy); else passed++;
    endtask

    task automatic test_basic();
        int n = 600, a = 5, rise = -1, fall = -1, bfall = -1, width = 0, nv = 0, lv = -1, vf = 0, m, f;
        prep();
        for (int k = 0; k < 10; k++) r[a+k] = 1;
        model(n, 0);
        run(n);
        for (int e = 0; e < n; e++) begin
            if (ob_out[e]) width++;
            if (ob_out[e] && rise < 0) rise = e;
            if (rise >= 0 && !ob_out[e] && fall < 0) begin fall = e; vf = ob_vld[e]; end
            if (fall >= 0 && !ob_busy[e] && bfall < 0) bfall = e;
            if (ob_vld[e]) begin nv++; lv = ob_len[e]; end
        end
        // in is raised just after edge a-1; out must be high SYNC+MIN+1 edges later
        total++; if (rise != a - 1 + SYNC + MIN + 1) $display("FAIL basic_latency: rise at edge %0d want %0d", rise, a - 1 + SYNC + MIN + 1); else passed++;
        total++; if (width != 10) $display("FAIL basic_width: got %0d want 10", width); else passed++;
        total++; if (nv != 1 || lv != 10) $display("FAIL basic_len: got %0d strobes len %0d want 1 strobe len 10", nv, lv); else passed++;
        total++; if (vf != 1) $display("FAIL basic_vld_at_fall: got %0d want 1", vf); else passed++;
        total++; if (bfall - fall != HOLD + 1) $display("FAIL basic_holdoff: busy fell %0d after out want %0d", bfall - fall, HOLD + 1); else passed++;
        m = trace_errs(n, f);
        total++; if (m != 0) $display("FAIL basic_trace: %0d mismatches first at edge %0d want 0", m, f); else passed++;
    endtask

    task automatic test_reject();
        int n = 60, a = 5, sfall = a + SYNC + 3, bfall = -1, width = 0, nv = 0, m, f;
        prep();
        for (int k = 0; k < 3; k++) r[a+k] = 1;
        model(n, 0);
        run(n);
        for (int e = 0; e < n; e++) begin
            if (ob_out[e]) width++;
            if (ob_vld[e]) nv++;
            if (e >= sfall && !ob_busy[e] && bfall < 0) bfall = e;
        end
        total++; if (rej_cnt !== 16'd1) $display("FAIL reject_cnt: got %0d want 1", rej_cnt); else passed++;
        total++; if (width != 0 || nv != 0) $display("FAIL reject_quiet: out cycles %0d strobes %0d want 0 0", width, nv); else passed++;
        total++; if (bfall < 0 || bfall - sfall > 2) $display("FAIL reject_busy: busy low at edge %0d want by %0d", bfall, sfall + 2); else passed++;
        m = trace_errs(n, f);
        total++; if (m != 0) $display("FAIL reject_trace: %0d mismatches first at edge %0d want 0", m, f); else passed++;
    endtask

    task automatic test_truncate();
        int n = 600, a = 5, width = 0, rises = 0, lv = -1, m, f;
        prep();
        for (int k = 0; k < 150; k++) r[a+k] = 1;
        model(n, 0);
        run(n);
        for (int e = 0; e < n; e++) begin
            if (ob_out[e]) width++;
            if (ob_out[e] && (e == 0 || !ob_out[e-1])) rises++;
            if (ob_vld[e]) lv = ob_len[e];
        end
        total++; if (width != 100 || rises != 1) $display("FAIL trunc_width: %0d cycles in %0d pulses want 100 in 1", width, rises); else passed++;
        total++; if (lv != 100) $display("FAIL trunc_len: got %0d want 100", lv); else passed++;
        total++; if (drop_cnt !== 16'd0) $display("FAIL trunc_drop: got %0d want 0", drop_cnt); else passed++;
        m = trace_errs(n, f);
        total++; if (m != 0) $display("FAIL trunc_trace: %0d mismatches first at edge %0d want 0", m, f); else passed++;
    endtask

    task automatic test_holdoff();
        int n = 1100, nv = 0, rises = 0, lsum = 0, m, f;
        prep();
        for (int k = 0; k < 10; k++) begin r[5+k] = 1; r[65+k] = 1; r[565+k] = 1; end
        model(n, 0);
        run(n);
        for (int e = 0; e < n; e++) begin
            if (ob_out[e] && (e == 0 || !ob_out[e-1])) rises++;
            if (ob_vld[e]) begin nv++; lsum += ob_len[e]; end
        end
        total++; if (rises != 2 || nv != 2) $display("FAIL holdoff_pulses: %0d pulses %0d strobes want 2 2", rises, nv); else passed++;
        total++; if (lsum != 20) $display("FAIL holdoff_len: len sum %0d want 20", lsum); else passed++;
        total++; if (drop_cnt !== 16'd1) $display("FAIL holdoff_drop: got %0d want 1", drop_cnt); else passed++;
        m = trace_errs(n, f);
        total++; if (m != 0) $display("FAIL holdoff_trace: %0d mismatches first at edge %0d want 0", m, f); else passed++;
    endtask

    task automatic test_arm();
        int n = 500, early = 0, width = 0, lv = -1, m, f;
        for (int k = 0; k < NMAX; k++) r[k] = 0;
        for (int k = 0; k < 30; k++) r[k] = 1;
        for (int k = 35; k < 43; k++) r[k] = 1;
        in = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model(n, 1);
        run(n);
        for (int e = 0; e < n; e++) begin
            if (ob_out[e] && e < 35) early++;
            if (ob_out[e]) width++;
            if (ob_vld[e]) lv = ob_len[e];
        end
        total++; if (early != 0) $display("FAIL arm_partial: %0d early out cycles want 0", early); else passed++;
        total++; if (width != 8 || lv != 8) $display("FAIL arm_pulse: width %0d len %0d want 8 8", width, lv); else passed++;
        m = trace_errs(n, f);
        total++; if (m != 0) $display("FAIL arm_trace: %0d mismatches first at edge %0d want 0", m, f); else passed++;
    endtask

    task automatic test_reset_mid();
        int n = 450, stray = 0, lv = -1, m, f;
        prep();
        in = 1'b1;
        repeat (2) tick();
        in = 1'b0;
        repeat (10) tick();
        total++; if (rej_cnt !== 16'd1) $display("FAIL mid_pre_rej: got %0d want 1", rej_cnt); else passed++;
        in = 1'b1;
        repeat (15) tick();
        total++; if (out !== 1'b1) $display("FAIL mid_pre_out: got %b want 1", out); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (out !== 1'b0 || len_vld !== 1'b0 || len !== '0) $display("FAIL mid_abort: out %b vld %b len %0d want 0 0 0", out, len_vld, len); else passed++;
        total++; if (rej_cnt !== '0 || drop_cnt !== '0) $display("FAIL mid_cnts: got %0d/%0d want 0/0", rej_cnt, drop_cnt); else passed++;
        tick();
        total++; if (busy !== 1'b1) $display("FAIL mid_arm: busy %b want 1", busy); else passed++;
        for (int k = 0; k < 10; k++) begin tick(); if (out) stray++; end
        total++; if (stray != 0) $display("FAIL mid_stray: %0d out cycles want 0", stray); else passed++;
        in = 1'b0;
        repeat (6) tick();
        for (int k = 0; k < NMAX; k++) r[k] = 0;
        for (int k = 3; k < 15; k++) r[k] = 1;
        model(n, 0);
        run(n);
        for (int e = 0; e < n; e++) if (ob_vld[e]) lv = ob_len[e];
        total++; if (lv != 12) $display("FAIL mid_after_len: got %0d want 12", lv); else passed++;
        m = trace_errs(n, f);
        total++; if (m != 0) $display("FAIL mid_after_trace: %0d mismatches first at edge %0d want 0", m, f); else passed++;
    endtask

    task automatic test_saturate();
        int n = 80, first_rej;
        prep();
        for (int p = 0; p < 5; p++) begin r[5+12*p] = 1; r[6+12*p] = 1; end
        model(n, 0);
        run(n);
        first_rej = ex_rej;
        total++; if (int'(rej_cnt) != first_rej) $display("FAIL sat_wide: got %0d want %0d", rej_cnt, first_rej); else passed++;
        total++; if (int'(rej2) != ((first_rej < 3) ? first_rej : 3)) $display("FAIL sat_narrow: got %0d want 3", rej2); else passed++;
        for (int k = 0; k < NMAX; k++) r[k] = 0;
        r[5] = 1; r[20] = 1;
        model(n, 0);
        run(n);
        total++; if (int'(rej_cnt) != first_rej + ex_rej) $display("FAIL sat_wide2: got %0d want %0d", rej_cnt, first_rej + ex_rej); else passed++;
        total++; if (rej2 !== 2'd3) $display("FAIL sat_hold: got %0d want 3", rej2); else passed++;
    endtask

    task automatic test_random();
        int pos, w, n, m, f;
        for (int round = 0; round < 3; round++) begin
            prep();
            pos = 5;
            while (pos < 2500) begin
                case ($urandom_range(2))
                    0: w = $urandom_range(5, 1);
                    1: w = $urandom_range(99, 6);
                    default: w = $urandom_range(140, 100);
                endcase
                for (int k = 0; k < w; k++) r[pos+k] = 1;
                pos += w;
                pos += $urandom_range(1) ? $urandom_range(80, 5) : $urandom_range(600, 420);
            end
            n = pos + 600;
            model(n, 0);
            run(n);
            m = trace_errs(n, f);
            total++; if (m != 0) $display("FAIL rand%0d_trace: %0d mismatches first at edge %0d want 0", round, m, f); else passed++;
            total++; if (int'(rej_cnt) != ex_rej) $display("FAIL rand%0d_rej: got %0d want %0d", round, rej_cnt, ex_rej); else passed++;
            total++; if (int'(drop_cnt) != ex_drop) $display("FAIL rand%0d_drop: got %0d want %0d", round, drop_cnt, ex_drop); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_truncate();
        test_holdoff();
        test_arm();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
